video_vga_dbl: RTL

- Scan-doubler sitting directly upstream of the palette/DAC output stage.
- Captures one TV line of 8-bit plex indices plus blank flag at TV pixel rate into a ping-pong line buffer.
- Replays the previously captured line twice at double pixel rate.
- Outputs: vgaplex, vga_blank, vga_hsync and vga_line (pass index, also used as PWM phase bit downstream).

---
 rtl/video_dbl_pkg.sv | 13 +
 rtl/video_dbl_lbuf.sv | 24 ++
 rtl/video_vga_dbl.sv | 118 +++++++++++
 3 files changed

// File: rtl/video_dbl_pkg.sv
// Shared constants and line-buffer word layout for the VGA scan-doubler.
package video_dbl_pkg;
  localparam int BLANK_BIT  = 8;
  localparam int PLEX_MSB   = 7;
  localparam int LBUF_W     = 9;
  localparam int ADDR_W_DEF = 9;
  localparam int HS_PIX_DEF = 52;

  typedef struct packed {
    logic                blank;
    logic [PLEX_MSB:0]   plex;
  } lbuf_word_t;
endpackage

// File: rtl/video_dbl_lbuf.sv
// Two-bank line buffer: write port a, registered read port b (1-clk latency).
module video_dbl_lbuf
  import video_dbl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [ADDR_W:0]  waddr,
  input  lbuf_word_t       wdata,
  input  logic             re,
  input  logic [ADDR_W:0]  raddr,
  output lbuf_word_t       rdata
);
  lbuf_word_t mem [2**(ADDR_W+1)];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/video_vga_dbl.sv
// Scan-doubler: captures a TV line into a ping-pong buffer and replays it twice.
// Optional black scanlines on the second pass with VGA_DBL_SCANLINES_EN.
module video_vga_dbl
  import video_dbl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int HS_PIX = HS_PIX_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tv_pix_stb,
  input  logic       vga_pix_stb,
  input  logic       tv_line_start,
  input  logic [7:0] vplex_in,
  input  logic       tv_blank,
  output logic [7:0] vgaplex,
  output logic       vga_blank,
  output logic       vga_hsync,
  output logic       vga_line,
  output logic       line_ovf
);
  localparam logic [ADDR_W:0] DEPTH  = (ADDR_W+1)'(2**ADDR_W);
  localparam logic [ADDR_W:0] HS_END = (ADDR_W+1)'(HS_PIX);
`ifdef VGA_DBL_SCANLINES_EN
  localparam logic SCANLINES = 1'b1;
`else
  localparam logic SCANLINES = 1'b0;
`endif

  logic            wr_bank, rd_bank, line_st, idle;
  logic            vld_q, hs_q, line_q;
  logic [ADDR_W:0] wr_cnt, rd_len, rd_addr;
  logic            cur_bank, cur_line, rd_go, nxt_line, nxt_idle;
  logic [ADDR_W:0] cur_addr, cur_len, nxt_addr;
  logic            we;
  logic [ADDR_W:0] waddr, raddr;
  lbuf_word_t      wdata, rdata;

  // wr_cnt is a pixel count, so a full 2^ADDR_W line fits; only the pixel after that overflows
  always_comb begin
    we    = tv_pix_stb & (tv_line_start | (wr_cnt != DEPTH));
    waddr = tv_line_start ? {~wr_bank, {ADDR_W{1'b0}}} : {wr_bank, wr_cnt[ADDR_W-1:0]};
    wdata = '{blank: tv_blank, plex: vplex_in};
  end

  // Line start resyncs the reader in the same clk, so a coincident strobe reads the new line
  always_comb begin
    cur_bank = tv_line_start ? wr_bank : rd_bank;
    cur_addr = tv_line_start ? '0      : rd_addr;
    cur_len  = tv_line_start ? wr_cnt  : rd_len;
    cur_line = tv_line_start ? 1'b0    : line_st;
    rd_go    = vga_pix_stb & (cur_len != '0) & (tv_line_start | ~idle);
    raddr    = {cur_bank, cur_addr[ADDR_W-1:0]};
    nxt_addr = cur_addr;
    nxt_line = cur_line;
    nxt_idle = tv_line_start ? 1'b0 : idle;
    if (rd_go) begin
      if (cur_addr == cur_len - 1'b1) begin
        nxt_addr = '0;
        if (cur_line) nxt_idle = 1'b1;
        else          nxt_line = 1'b1;
      end else begin
        nxt_addr = cur_addr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank  <= 1'b0;
      wr_cnt   <= '0;
      line_ovf <= 1'b0;
      rd_len   <= '0;
      rd_bank  <= 1'b0;
      rd_addr  <= '0;
      line_st  <= 1'b0;
      idle     <= 1'b0;
      vld_q    <= 1'b0;
      hs_q     <= 1'b0;
      line_q   <= 1'b0;
    end else begin
      if (tv_line_start) begin
        wr_bank <= ~wr_bank;
        rd_bank <= wr_bank;
        rd_len  <= wr_cnt;
        wr_cnt  <= {{ADDR_W{1'b0}}, tv_pix_stb};
      end else if (tv_pix_stb) begin
        if (wr_cnt == DEPTH) line_ovf <= 1'b1;
        else                 wr_cnt   <= wr_cnt + 1'b1;
      end
      rd_addr <= nxt_addr;
      line_st <= nxt_line;
      idle    <= nxt_idle;
      // Flags ride alongside the RAM read so they line up with its output
      if (vga_pix_stb) begin
        vld_q  <= rd_go;
        hs_q   <= rd_go & (cur_addr < HS_END);
        line_q <= cur_line;
      end
    end
  end

  video_dbl_lbuf #(.ADDR_W(ADDR_W)) u_lbuf (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .re    (rd_go),
    .raddr (raddr),
    .rdata (rdata)
  );

  assign vgaplex   = vld_q ? rdata.plex : '0;
  assign vga_blank = ~vld_q | rdata.blank | (SCANLINES & line_q);
  assign vga_hsync = hs_q;
  assign vga_line  = line_q;
endmodule
